// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader: stream field
// widths and the loader state encoding.
package mips_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int LEN_W      = 16;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    // ST_CSUM is only reachable when IMEM_LOAD_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte stream in, instruction-memory write port out.
// Handshake: a byte moves on a rising clock edge where in_valid and in_ready
// are both 1; in_data must be stable while in_valid is 1 and the byte has not
// yet moved; in_ready may drop at any time and in_valid is never required to
// wait for in_ready. The write port has no back-pressure: imem_we is a
// one-cycle pulse with imem_addr/imem_wdata valid in the same cycle.
interface imem_boot_loader_if;
    import mips_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    // Host / byte source plus memory side.
    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word and pulses word_valid for
// one cycle after the fourth byte of a word has been shifted in.
module imem_boot_loader_byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_cnt,
    output logic              word_valid
);

    // Shift register, byte counter and registered word-complete pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            word       <= '0;
            byte_cnt   <= 2'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (byte_cnt == 2'd3);
            if (byte_valid) begin
                word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a 16-bit big-endian word count and
// then the program words as a byte stream, writes them to consecutive word
// addresses from BASE_ADDR and holds the core in reset until loading is done.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match all header and data bytes before the core is released.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    input  logic                reload,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output loader_state_t       state
);

    // Largest legal word count is the full memory capacity.
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_WIDTH;

    logic              ready_q;
    logic [31:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  word_cnt_next;
    logic [LEN_W-1:0]  len_next;
    logic              accept;
    logic              data_byte;
    logic              last_byte;
    logic [WORD_W-1:0] packed_word;
    logic [1:0]        byte_cnt;
    logic              word_valid;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    assign accept        = bus.in_valid & ready_q;
    assign data_byte     = accept && (state == ST_DATA);
    assign len_next      = {len_q[LEN_W-1:BYTE_W], bus.in_data};
    assign word_cnt_next = word_cnt + LEN_W'(1);
    // Fourth byte of the final word is being accepted.
    assign last_byte     = data_byte && (byte_cnt == 2'd3) && (word_cnt_next == len_q);

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = packed_word;

    imem_boot_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (bus.in_data),
        .byte_valid (data_byte),
        .word       (packed_word),
        .byte_cnt   (byte_cnt),
        .word_valid (word_valid)
    );

    // Loader FSM with registered handshake/status outputs, address and word counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LEN_HI;
            ready_q   <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            addr_q    <= BASE_ADDR;
            len_q     <= '0;
            word_cnt  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            // Address moves on after every write pulse, whatever the state.
            if (word_valid) addr_q <= addr_q + 32'd4;
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (accept && (state == ST_LEN_HI || state == ST_LEN_LO || state == ST_DATA))
                csum_q <= csum_q ^ bus.in_data;
`endif
            case (state)
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q[LEN_W-1:BYTE_W] <= bus.in_data;
                        state                 <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_q    <= len_next;
                        word_cnt <= '0;
                        if (len_next == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                            state     <= ST_CSUM;
`else
                            state     <= ST_DONE;
                            ready_q   <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
`endif
                        end else if ({1'b0, len_next} > MAX_WORDS) begin
                            state   <= ST_ERR;
                            ready_q <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_byte && byte_cnt == 2'd3) word_cnt <= word_cnt_next;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    // The last word's write pulse lands while CSUM waits for its byte.
                    if (last_byte) state <= ST_CSUM;
`else
                    // Stop taking bytes once the last one is in, release after its write.
                    if (last_byte) ready_q <= 1'b0;
                    if (word_valid && word_cnt == len_q) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end
`endif
                end
`ifdef IMEM_LOAD_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (bus.in_data == csum_q) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERR: begin
                    if (reload) begin
                        state     <= ST_LEN_HI;
                        ready_q   <= 1'b1;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        addr_q    <= BASE_ADDR;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                default: begin
                    state <= ST_LEN_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader (default build, ADDR_WIDTH=8,
// BASE_ADDR=0): normal load, empty load, oversize header, gapped stream,
// reset mid-load and the largest legal word count.
module tb_imem_boot_loader;
    import mips_pkg::*;

    logic          clk;
    logic          reset;
    logic          reload;
    logic          cpu_reset;
    logic          done;
    logic          error;
    loader_state_t state;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    logic [63:0] exp_q[$];

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .ADDR_WIDTH (8),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .reload    (reload),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .state     (state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {bus.imem_addr, bus.imem_wdata}, 64'hx);
            end else begin
                check("write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
            end
        end
    end

    // Offer one byte after `gap` idle cycles; returns 1 ns after the edge that takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic ok;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 64'(n), 64'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic expect_prog();
        exp_q.push_back({32'h0000_0000, 32'h2008_0005});
        exp_q.push_back({32'h0000_0004, 32'h0109_5020});
    endtask

    task automatic check_done_after_prog(input string tag);
        // Last byte just taken: write pulse now, core still held.
        check({tag, "_we_last"}, 64'(bus.imem_we), 64'd1);
        check({tag, "_cpu_reset_during_we"}, 64'(cpu_reset), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_cpu_reset_released"}, 64'(cpu_reset), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_addr_end"}, 64'(bus.imem_addr), 64'h8);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    logic [7:0] prog[$];
    int         w0;

    initial begin
        prog = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        reset        = 1'b1;
        reload       = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'h0);
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'h0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_state", 64'(state), 64'(ST_LEN_HI));
        @(posedge clk);
        #1;

        // Two-word program, one byte per cycle.
        expect_prog();
        send_stream(prog, 0);
        check_done_after_prog("prog");

        // Reload, then empty program.
        pulse_reload();
        check("reload_in_ready", 64'(bus.in_ready), 64'd1);
        check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
        check("reload_done", 64'(done), 64'd0);
        check("reload_addr", 64'(bus.imem_addr), 64'h0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("empty_done", 64'(done), 64'd1);
        check("empty_cpu_reset", 64'(cpu_reset), 64'd0);
        check("empty_in_ready", 64'(bus.in_ready), 64'd0);

        // Oversize header: 257 words into a 256-word memory.
        pulse_reload();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("big_error", 64'(error), 64'd1);
        check("big_cpu_reset", 64'(cpu_reset), 64'd1);
        check("big_in_ready", 64'(bus.in_ready), 64'd0);
        check("big_done", 64'(done), 64'd0);
        // Bytes offered while in_ready is low are ignored.
        w0 = writes;
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("big_no_writes", 64'(writes - w0), 64'd0);
        check("big_state", 64'(state), 64'(ST_ERR));

        // Same program with random idle gaps.
        pulse_reload();
        expect_prog();
        send_stream(prog, 3);
        check_done_after_prog("gap");

        // Reset after two data bytes: partial word dropped, reload from base.
        pulse_reload();
        w0 = writes;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_write", 64'(writes - w0), 64'd0);
        check("midrst_addr", 64'(bus.imem_addr), 64'h0);
        check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        expect_prog();
        send_stream(prog, 1);
        check_done_after_prog("midrst");

        // Largest legal count (256) is accepted and goes to DATA.
        pulse_reload();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        check("max_state", 64'(state), 64'(ST_DATA));
        check("max_error", 64'(error), 64'd0);
        check("max_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (4) @(posedge clk);
        check("total_writes", 64'(writes), 64'd6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
